// File: rtl/mxalu12s.sv
// Slice-iterative ALU: one SLICE-bit chunk per clock, LSB first, carry rippled through a register.
// Result and C/Z/N/V flags commit together when the last slice completes; valid/ready on both sides.
module mxalu12s #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cs_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             c_flag,
  output logic             z_flag,
  output logic             n_flag,
  output logic             v_flag,
  output logic             busy
);
  localparam int N  = WIDTH / SLICE;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  if ((SLICE < 1) || (WIDTH % SLICE != 0)) begin : g_bad_param
    $error("mxalu12s: WIDTH must be a positive multiple of SLICE");
  end

  localparam logic [3:0] OP_ADD = 4'h0, OP_ADC = 4'h1, OP_SUB = 4'h2, OP_SBC = 4'h3,
                         OP_AND = 4'h4, OP_OR  = 4'h5, OP_XOR = 4'h6, OP_NOT = 4'h7,
                         OP_PSA = 4'h8, OP_PSB = 4'h9, OP_INC = 4'hA, OP_DEC = 4'hB,
                         OP_SHL = 4'hC, OP_RLC = 4'hD, OP_CMP = 4'hE, OP_NOP = 4'hF;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [3:0]       op_reg;
  logic [WIDTH-1:0] a_reg, b_reg, shadow_reg;
  logic             carry_reg, zacc_reg;
  logic [KW-1:0]    k_reg;

  // Operands are shifted right each slice, so the active slice is always the low bits.
  logic [SLICE-1:0] a_s, b_s, bb, slice_res;
  logic [SLICE:0]   sum, sh;
  logic             arith, shift, cout, v_calc, last;
  logic [WIDTH-1:0] res_full;

  assign a_s = a_reg[SLICE-1:0];
  assign b_s = b_reg[SLICE-1:0];
  assign sum = {1'b0, a_s} + {1'b0, bb} + {{SLICE{1'b0}}, carry_reg};
  assign sh  = {a_s, carry_reg};

  always_comb begin
    bb        = b_s;
    arith     = 1'b0;
    shift     = 1'b0;
    slice_res = '0;
    cout      = 1'b0;
    case (op_reg)
      OP_ADD, OP_ADC:         begin arith = 1'b1; bb = b_s;  end
      OP_SUB, OP_SBC, OP_CMP: begin arith = 1'b1; bb = ~b_s; end
      OP_INC:                 begin arith = 1'b1; bb = '0;   end
      OP_DEC:                 begin arith = 1'b1; bb = '1;   end
      OP_SHL, OP_RLC:         shift = 1'b1;
      OP_AND:                 slice_res = a_s & b_s;
      OP_OR:                  slice_res = a_s | b_s;
      OP_XOR:                 slice_res = a_s ^ b_s;
      OP_NOT:                 slice_res = ~a_s;
      OP_PSA:                 slice_res = a_s;
      OP_PSB:                 slice_res = b_s;
      default:                slice_res = '0;
    endcase
    if (arith) begin
      slice_res = sum[SLICE-1:0];
      cout      = sum[SLICE];
    end else if (shift) begin
      slice_res = sh[SLICE-1:0];
      cout      = sh[SLICE];
    end
  end

  // Signed overflow from operand/result sign agreement equals carry-in XOR carry-out of the MSB.
  assign v_calc   = arith && (a_s[SLICE-1] == bb[SLICE-1]) && (slice_res[SLICE-1] != a_s[SLICE-1]);
  assign res_full = (shadow_reg >> SLICE) | (WIDTH'(slice_res) << (WIDTH - SLICE));
  assign last     = (k_reg == KW'(N - 1));

  assign in_ready = (state == IDLE) && !cs_n;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      op_reg     <= OP_NOP;
      a_reg      <= '0;
      b_reg      <= '0;
      shadow_reg <= '0;
      carry_reg  <= 1'b0;
      zacc_reg   <= 1'b0;
      k_reg      <= '0;
      out_valid  <= 1'b0;
      f          <= '0;
      c_flag     <= 1'b0;
      z_flag     <= 1'b0;
      n_flag     <= 1'b0;
      v_flag     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid && !cs_n) begin
          op_reg   <= opcode;
          a_reg    <= a;
          b_reg    <= b;
          zacc_reg <= 1'b0;
          k_reg    <= '0;
          case (opcode)
            OP_ADC, OP_SBC, OP_RLC: carry_reg <= c_flag;
            OP_SUB, OP_CMP, OP_INC: carry_reg <= 1'b1;
            default:                carry_reg <= 1'b0;
          endcase
          state <= RUN;
        end
        RUN: begin
          a_reg      <= a_reg >> SLICE;
          b_reg      <= b_reg >> SLICE;
          shadow_reg <= res_full;
          carry_reg  <= cout;
          zacc_reg   <= zacc_reg | (|slice_res);
          k_reg      <= k_reg + KW'(1);
          if (last) begin
            state     <= DONE;
            out_valid <= 1'b1;
            if (op_reg != OP_CMP && op_reg != OP_NOP) f <= res_full;
            if (op_reg != OP_NOP) begin
              c_flag <= cout;
              z_flag <= !(zacc_reg | (|slice_res));
              n_flag <= slice_res[SLICE-1];
              v_flag <= v_calc;
            end
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mxalu12s.sv
// Directed bench for mxalu12s at WIDTH=16/SLICE=4: arithmetic, flags, chaining, backpressure, reset.
module tb_mxalu12s;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  opcode = 4'h0;
  logic [15:0] a = '0, b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] f;
  logic        c_flag, z_flag, n_flag, v_flag, busy;

  int total = 0;
  int bad = 0;

  mxalu12s #(.WIDTH(16), .SLICE(4)) dut (
    .clk(clk), .rst(rst), .cs_n(cs_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .f(f), .c_flag(c_flag), .z_flag(z_flag), .n_flag(n_flag), .v_flag(v_flag), .busy(busy)
  );

  always #5 clk = ~clk;

  // Issues one request and returns the number of edges from acceptance to out_valid (-1 on timeout).
  task automatic run_op(input logic [3:0] op, input logic [15:0] av, input logic [15:0] bv,
                        output int lat);
    @(negedge clk);
    opcode = op; a = av; b = bv; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin lat = i; break; end
    end
    total++;
    if (lat < 0) begin
      bad++;
      $display("FAIL timeout op=%h: out_valid never rose", op);
    end
    $display("op=%h a=%h b=%h -> f=%h czvn=%b%b%b%b lat=%0d", op, av, bv, f,
             c_flag, z_flag, v_flag, n_flag, lat);
  endtask

  task automatic take_result();
    @(negedge clk) out_ready = 1'b1;
    @(negedge clk) out_ready = 1'b0;
  endtask

  task automatic check_res(input string name, input logic [15:0] ef, input logic [3:0] eflags);
    total++;
    if (f !== ef || {c_flag, z_flag, n_flag, v_flag} !== eflags) begin
      bad++;
      $display("FAIL %s: f=%h czn v=%b%b%b%b, need f=%h czn v=%b", name, f,
               c_flag, z_flag, n_flag, v_flag, ef, eflags);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if (f !== 16'h0 || {c_flag, z_flag, n_flag, v_flag} !== 4'b0 || out_valid !== 1'b0 ||
        busy !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_state: f=%h flags=%b ov=%b busy=%b ir=%b, need 0/0/0/0/1", f,
               {c_flag, z_flag, n_flag, v_flag}, out_valid, busy, in_ready);
    end
    rst = 1'b0;
    $display("reset released");
  endtask

  task automatic test_add();
    int lat;
    run_op(4'h0, 16'h00FF, 16'h0001, lat);
    total++;
    if (lat !== 4) begin bad++; $display("FAIL latency: got %0d need 4", lat); end
    check_res("add_basic", 16'h0100, 4'b0000);
    take_result();
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL after_take: ov=%b busy=%b need 0 0", out_valid, busy);
    end
  endtask

  task automatic test_chain();
    int lat;
    run_op(4'h0, 16'hFFFF, 16'h0001, lat);
    check_res("add_wrap", 16'h0000, 4'b1100);
    take_result();
    run_op(4'h1, 16'h0000, 16'h0000, lat);
    check_res("adc_chain", 16'h0001, 4'b0000);
    take_result();
  endtask

  task automatic test_overflow();
    int lat;
    run_op(4'h0, 16'h7FFF, 16'h0001, lat);
    check_res("add_ovf", 16'h8000, 4'b0011);
    take_result();
    run_op(4'h2, 16'h0000, 16'h0001, lat);
    check_res("sub_borrow", 16'hFFFF, 4'b0010);
    take_result();
    run_op(4'hB, 16'h0000, 16'h0000, lat);
    check_res("dec_zero", 16'hFFFF, 4'b0010);
    take_result();
  endtask

  task automatic test_cmp_shift();
    int lat;
    run_op(4'h8, 16'h1234, 16'hFFFF, lat);
    check_res("pass_a", 16'h1234, 4'b0000);
    take_result();
    run_op(4'hE, 16'h5555, 16'h5555, lat);
    check_res("cmp_eq", 16'h1234, 4'b1100);
    take_result();
    run_op(4'hD, 16'h8001, 16'h0000, lat);
    check_res("rolc_c1", 16'h0003, 4'b1000);
    take_result();
    run_op(4'hF, 16'hAAAA, 16'h5555, lat);
    check_res("nop_hold", 16'h0003, 4'b1000);
    take_result();
    run_op(4'h6, 16'hF0F0, 16'hFF00, lat);
    check_res("xor", 16'h0FF0, 4'b0000);
    take_result();
    run_op(4'hC, 16'hC001, 16'h0000, lat);
    check_res("shl", 16'h8002, 4'b1010);
    take_result();
  endtask

  task automatic test_backpressure();
    int lat;
    run_op(4'h0, 16'h1111, 16'h2222, lat);
    check_res("bp_result", 16'h3333, 4'b0000);
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 5) cs_n = 1'b1;
      total++;
      if (out_valid !== 1'b1 || f !== 16'h3333 || {c_flag, z_flag, n_flag, v_flag} !== 4'b0 ||
          in_ready !== 1'b0 || busy !== 1'b1) begin
        bad++;
        $display("FAIL bp_hold[%0d]: ov=%b f=%h ir=%b busy=%b, need 1 3333 0 1", i, out_valid,
                 f, in_ready, busy);
      end
    end
    in_valid = 1'b0;
    take_result();
    // cs_n still high: the held request must not be accepted.
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
        bad++;
        $display("FAIL cs_block[%0d]: busy=%b ir=%b ov=%b need 0 0 0", i, busy, in_ready, out_valid);
      end
    end
    in_valid = 1'b0;
    cs_n = 1'b0;
    $display("backpressure and chip-select done");
  endtask

  task automatic test_reset_mid_run();
    int lat;
    @(negedge clk);
    opcode = 4'h0; a = 16'hFFFF; b = 16'h0001; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    total++;
    if (f !== 16'h0 || {c_flag, z_flag, n_flag, v_flag} !== 4'b0 || out_valid !== 1'b0 ||
        busy !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_run: f=%h flags=%b ov=%b busy=%b need 0", f,
               {c_flag, z_flag, n_flag, v_flag}, out_valid, busy);
    end
    rst = 1'b0;
    run_op(4'h0, 16'h0002, 16'h0003, lat);
    total++;
    if (lat !== 4) begin bad++; $display("FAIL post_rst_latency: got %0d need 4", lat); end
    check_res("post_rst_add", 16'h0005, 4'b0000);
    take_result();
  endtask

  initial begin
    test_reset();
    test_add();
    test_chain();
    test_overflow();
    test_cmp_shift();
    test_backpressure();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
